// File: rtl/adc_sample_sink_s_axi_lite_if.sv
// AXI4-Lite write-only channel bundle (AW/W/B) between the ADC master and the sample sink.
interface adc_sample_sink_s_axi_lite_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );
endinterface

// File: rtl/adc_sample_sink_s_axi_lite.sv
// AXI4-Lite write sink: in-window writes are queued as {idx,data} in a FWFT FIFO, others get SLVERR.
// Response one cycle after both captures; a full FIFO stalls the response until a pop frees a slot.
module adc_sample_sink_s_axi_lite #(
    parameter int unsigned                    C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                    C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_BASE_ADDR      = 32'h4000_0000,
    parameter int unsigned                    C_S_WINDOW_BYTES   = 16,
    parameter int unsigned                    C_FIFO_DEPTH       = 16,
    localparam int unsigned IW = (C_S_WINDOW_BYTES / 4 > 1) ? $clog2(C_S_WINDOW_BYTES / 4) : 1,
    localparam int unsigned CW = $clog2(C_FIFO_DEPTH) + 1
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    adc_sample_sink_s_axi_lite_if.slave   s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] SAMPLE_DATA,
    output logic [IW-1:0]                 SAMPLE_IDX,
    output logic                          SAMPLE_VALID,
    input  logic                          SAMPLE_READY,
    output logic [CW-1:0]                 FIFO_COUNT,
    output logic                          ERR_STICKY
);
    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned PW = $clog2(C_FIFO_DEPTH);

    typedef enum logic [1:0] {COLLECT, COMMIT, RESP} state_e;

    state_e        state_q, state_d;
    logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic          awready_q, wready_q;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          err_q, err_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW+DW-1:0] mem_q [C_FIFO_DEPTH];
    logic [IW+DW-1:0] head;

    logic [AW-1:0] offset;
    logic          inwin, fifo_full, push, pop;

    assign offset    = aw_addr_q - C_S_BASE_ADDR;
    assign inwin     = (aw_addr_q >= C_S_BASE_ADDR) && (offset < AW'(C_S_WINDOW_BYTES))
                       && (aw_addr_q[1:0] == 2'b00);
    assign fifo_full = (count_q == CW'(C_FIFO_DEPTH));
    assign pop       = SAMPLE_VALID && SAMPLE_READY;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        err_d     = err_q;
        push      = 1'b0;

        if (s_axi.S_AXI_AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi.S_AXI_AWADDR;
        end
        if (s_axi.S_AXI_WVALID && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.S_AXI_WDATA;
        end

        case (state_q)
            COLLECT: if (aw_full_d && w_full_d) state_d = COMMIT;
            COMMIT: begin
                if (!inwin) begin
                    bresp_d  = 2'b10;
                    bvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else if (!fifo_full || pop) begin
                    // a same-cycle pop frees the slot this push lands in
                    push     = 1'b1;
                    bresp_d  = 2'b00;
                    bvalid_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: if (s_axi.S_AXI_BREADY) begin
                bvalid_d  = 1'b0;
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                state_d   = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q   <= COLLECT;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            err_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            err_q     <= err_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push && !S_AXI_ARESET) mem_q[wr_ptr_q] <= {offset[IW+1:2], w_data_q};
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;

    // head is masked so the sample port reads zero whenever the FIFO is empty
    assign SAMPLE_VALID = (count_q != '0);
    assign SAMPLE_DATA  = SAMPLE_VALID ? head[DW-1:0] : '0;
    assign SAMPLE_IDX   = SAMPLE_VALID ? head[IW+DW-1:DW] : '0;
    assign FIFO_COUNT   = count_q;
    assign ERR_STICKY   = err_q;
endmodule

// File: tb/tb_adc_sample_sink_s_axi_lite.sv
// Directed bench with response/sample scoreboards for the AXI4-Lite ADC sample sink.
module tb_adc_sample_sink_s_axi_lite;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sdata;
    logic [1:0]  sidx;
    logic        svalid;
    logic        sready = 1'b0;
    logic [4:0]  cnt;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int b_seen = 0;
    logic [33:0] exp_s[$];
    logic [1:0]  exp_b[$];

    adc_sample_sink_s_axi_lite_if #(.AW(32), .DW(32)) axi ();

    adc_sample_sink_s_axi_lite dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .s_axi       (axi),
        .SAMPLE_DATA (sdata),
        .SAMPLE_IDX  (sidx),
        .SAMPLE_VALID(svalid),
        .SAMPLE_READY(sready),
        .FIFO_COUNT  (cnt),
        .ERR_STICKY  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference decode: what the sink should answer and what it should queue
    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        if (a >= BASE && a < BASE + 32'd16 && a[1:0] == 2'b00) begin
            exp_s.push_back({off[3:2], d});
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d);
        logic aw_done, w_done, hs_aw, hs_w;
        int t;
        aw_done = 1'b0; w_done = 1'b0; t = 0;
        expect_write(a, d);
        axi.S_AXI_AWADDR  = a;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = d;
        axi.S_AXI_WVALID  = 1'b1;
        while (!(aw_done && w_done) && t < 50) begin
            hs_aw = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            hs_w  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            tick();
            if (hs_aw) begin aw_done = 1'b1; axi.S_AXI_AWVALID = 1'b0; end
            if (hs_w)  begin w_done = 1'b1;  axi.S_AXI_WVALID = 1'b0; end
            t++;
        end
        check("send_handshake", 64'(aw_done && w_done), 64'd1);
    endtask

    task automatic wait_b();
        logic hs;
        int t;
        hs = 1'b0; t = 0;
        while (!hs && t < 50) begin
            hs = axi.S_AXI_BVALID && axi.S_AXI_BREADY;
            tick();
            t++;
        end
        check("b_handshake", 64'(hs), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 64'(axi.S_AXI_AWREADY), 64'd0);
        check({tag, "_wready"},  64'(axi.S_AXI_WREADY),  64'd0);
        check({tag, "_bvalid"},  64'(axi.S_AXI_BVALID),  64'd0);
        check({tag, "_bresp"},   64'(axi.S_AXI_BRESP),   64'd0);
        check({tag, "_svalid"},  64'(svalid), 64'd0);
        check({tag, "_count"},   64'(cnt),    64'd0);
        check({tag, "_err"},     64'(err),    64'd0);
        check({tag, "_sidx"},    64'(sidx),   64'd0);
        check({tag, "_sdata"},   64'(sdata),  64'd0);
    endtask

    // monitors sample mid-cycle, before the edge that completes the handshake
    always @(negedge clk) begin
        if (!rst && axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
            b_seen++;
            if (exp_b.size() == 0) check("b_expected_pending", 64'd0, 64'd1);
            else check("bresp", 64'(axi.S_AXI_BRESP), 64'(exp_b.pop_front()));
        end
        if (!rst && svalid && sready) begin
            if (exp_s.size() == 0) check("sample_expected_pending", 64'd0, 64'd1);
            else check("sample_idx_data", 64'({sidx, sdata}), 64'(exp_s.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0;  axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b0;

        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("awready_after_reset", 64'(axi.S_AXI_AWREADY), 64'd1);
        check("wready_after_reset",  64'(axi.S_AXI_WREADY),  64'd1);

        // single in-window write
        axi.S_AXI_BREADY = 1'b1;
        send(BASE, 32'h1234_5678);
        check("t1_bvalid_at_capture", 64'(axi.S_AXI_BVALID), 64'd0);
        tick();
        check("t1_bvalid", 64'(axi.S_AXI_BVALID), 64'd1);
        check("t1_bresp",  64'(axi.S_AXI_BRESP),  64'd0);
        check("t1_svalid", 64'(svalid), 64'd1);
        check("t1_sdata",  64'(sdata),  64'h1234_5678);
        check("t1_sidx",   64'(sidx),   64'd0);
        check("t1_count",  64'(cnt),    64'd1);
        wait_b();
        check("t1_bvalid_cleared", 64'(axi.S_AXI_BVALID), 64'd0);
        check("t1_awready_back",   64'(axi.S_AXI_AWREADY), 64'd1);
        sready = 1'b1;
        tick();
        sready = 1'b0;
        check("t1_count_after_pop", 64'(cnt), 64'd0);

        // four consecutive word addresses, drained on the fly
        sready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(BASE + 32'(4 * i), 32'hA0 + 32'(i));
            wait_b();
        end
        repeat (3) tick();
        check("t2_count", 64'(cnt), 64'd0);
        check("t2_samples_left", 64'(exp_s.size()), 64'd0);

        // W arrives three cycles ahead of AW
        expect_write(BASE + 32'd8, 32'h0000_C3C3);
        axi.S_AXI_WDATA  = 32'h0000_C3C3;
        axi.S_AXI_WVALID = 1'b1;
        tick();
        axi.S_AXI_WVALID = 1'b0;
        check("t3_wready_after_capture", 64'(axi.S_AXI_WREADY), 64'd0);
        tick(); tick();
        check("t3_wready_held", 64'(axi.S_AXI_WREADY), 64'd0);
        check("t3_no_early_b",  64'(axi.S_AXI_BVALID), 64'd0);
        b0 = b_seen;
        axi.S_AXI_AWADDR  = BASE + 32'd8;
        axi.S_AXI_AWVALID = 1'b1;
        tick();
        axi.S_AXI_AWVALID = 1'b0;
        check("t3_awready_after_capture", 64'(axi.S_AXI_AWREADY), 64'd0);
        repeat (6) tick();
        check("t3_one_response", 64'(b_seen - b0), 64'd1);
        check("t3_count", 64'(cnt), 64'd0);

        // out-of-window and misaligned writes
        check("t4_err_before", 64'(err), 64'd0);
        send(BASE + 32'h10, 32'h0000_BAD0);
        wait_b();
        send(BASE + 32'h2, 32'h0000_BAD1);
        wait_b();
        check("t4_count", 64'(cnt), 64'd0);
        check("t4_err", 64'(err), 64'd1);

        // fill the FIFO, stall the 17th write, release it with one pop
        sready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(BASE + 32'(4 * (i % 4)), 32'h5000 + 32'(i));
            wait_b();
        end
        check("t5_count_full", 64'(cnt), 64'd16);
        send(BASE + 32'd4, 32'h0000_5010);
        for (int i = 0; i < 4; i++) begin
            check("t5_bvalid_stalled", 64'(axi.S_AXI_BVALID), 64'd0);
            tick();
        end
        check("t5_count_stalled", 64'(cnt), 64'd16);
        sready = 1'b1;
        tick();
        sready = 1'b0;
        check("t5_bvalid_after_pop", 64'(axi.S_AXI_BVALID), 64'd1);
        check("t5_count_after_pop",  64'(cnt), 64'd16);
        wait_b();
        sready = 1'b1;
        repeat (20) tick();
        sready = 1'b0;
        check("t5_count_drained", 64'(cnt), 64'd0);
        check("t5_samples_left", 64'(exp_s.size()), 64'd0);

        // response held under BREADY=0, then reset mid-hold
        axi.S_AXI_BREADY = 1'b0;
        send(BASE + 32'hC, 32'h0000_0066);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t6_bvalid_hold",  64'(axi.S_AXI_BVALID),  64'd1);
            check("t6_bresp_hold",   64'(axi.S_AXI_BRESP),   64'd0);
            check("t6_awready_hold", 64'(axi.S_AXI_AWREADY), 64'd0);
            check("t6_wready_hold",  64'(axi.S_AXI_WREADY),  64'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        check_reset_outputs("t6_reset");
        exp_b.delete();
        exp_s.delete();
        rst = 1'b0;
        axi.S_AXI_BREADY = 1'b1;
        tick();
        check("t6_awready_release", 64'(axi.S_AXI_AWREADY), 64'd1);
        check("t6_wready_release",  64'(axi.S_AXI_WREADY),  64'd1);

        // sink is usable again after the reset
        sready = 1'b1;
        send(BASE + 32'd4, 32'h0000_0077);
        wait_b();
        repeat (3) tick();
        check("post_samples_left", 64'(exp_s.size()), 64'd0);
        check("post_resps_left",   64'(exp_b.size()), 64'd0);
        check("post_count",        64'(cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
